// File: rtl/mul_wb_arbiter.sv
// mul_wb_arbiter: writeback stage behind the multiplier.
// Keeps an in-order tag queue of multiply destinations and pairs each returning
// result with its rd. The single register-file write port is shared between the
// 1-cycle ALU path and buffered multiply results. A starvation counter forces a
// MUL win after STARVE_LIMIT consecutive ALU wins while a filled head waits.
module mul_wb_arbiter #(
  parameter int WD_SIZE       = 32,
  parameter int REG_ADDR_SIZE = 5,
  parameter int TAG_DEPTH     = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  // multiply issue side
  input  logic                     mul_issue_i,
  input  logic [REG_ADDR_SIZE-1:0] mul_rd_i,
  output logic                     mul_stall_o,
  // multiply result side
  input  logic                     mul_valid_result_i,
  input  logic [WD_SIZE-1:0]       mul_result_i,
  // ALU result side
  input  logic                     alu_valid_i,
  input  logic [REG_ADDR_SIZE-1:0] alu_rd_i,
  input  logic [WD_SIZE-1:0]       alu_result_i,
  output logic                     alu_stall_o,
  // register-file write port
  output logic                     wb_en_o,
  output logic [REG_ADDR_SIZE-1:0] wb_rd_o,
  output logic [WD_SIZE-1:0]       wb_data_o,
  output logic                     err_o
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] L_FULL = CW'(TAG_DEPTH);
  localparam logic [SW-1:0] L_SLIM = SW'(STARVE_LIMIT);

  // tag queue storage
  logic [REG_ADDR_SIZE-1:0] r_tag_rd   [TAG_DEPTH];
  logic [WD_SIZE-1:0]       r_tag_data [TAG_DEPTH];
  logic [TAG_DEPTH-1:0]     r_tag_filled;

  // queue pointers and occupancy
  logic [PW-1:0] r_head;      // retire
  logic [PW-1:0] r_tail;      // alloc
  logic [PW-1:0] r_fill;      // next entry awaiting a result
  logic [CW-1:0] r_count;     // allocated entries
  logic [CW-1:0] r_unfilled;  // allocated entries still waiting for data

  logic [SW-1:0] r_starve;

  logic                     r_wb_en;
  logic [REG_ADDR_SIZE-1:0] r_wb_rd;
  logic [WD_SIZE-1:0]       r_wb_data;
  logic                     r_err;

  logic w_full;
  logic w_issue_ok;
  logic w_fill_ok;
  logic w_head_rdy;
  logic w_starved;
  logic w_mul_win;
  logic w_alu_win;

  // Slot availability is judged on the registered count only, so a same-cycle
  // retire never makes room for a same-cycle issue.
  assign w_full     = (r_count == L_FULL);
  assign w_issue_ok = mul_issue_i && !w_full;
  // A result needs an entry that was allocated and unfilled before this cycle;
  // an issue in the same cycle cannot be the one it completes.
  assign w_fill_ok  = mul_valid_result_i && (r_unfilled != '0);

  assign w_head_rdy = (r_count != '0) && r_tag_filled[r_head];
  assign w_starved  = (r_starve == L_SLIM) && w_head_rdy;
  assign w_mul_win  = w_starved || (!alu_valid_i && w_head_rdy);
  assign w_alu_win  = alu_valid_i && !w_starved;

  assign mul_stall_o = w_full;
  assign alu_stall_o = alu_valid_i && w_starved;
  assign wb_en_o     = r_wb_en;
  assign wb_rd_o     = r_wb_rd;
  assign wb_data_o   = r_wb_data;
  assign err_o       = r_err;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else begin
      if (w_issue_ok) r_tail <= r_tail + PW'(1);
      if (w_fill_ok)  r_fill <= r_fill + PW'(1);
      if (w_mul_win)  r_head <= r_head + PW'(1);
      case ({w_issue_ok, w_mul_win})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_issue_ok, w_fill_ok})
        2'b10:   r_unfilled <= r_unfilled + CW'(1);
        2'b01:   r_unfilled <= r_unfilled - CW'(1);
        default: r_unfilled <= r_unfilled;
      endcase
    end
  end

  // Tag entries: issue allocates rd, result fills data, retire clears filled.
  // The three never target the same index in one cycle (head is filled, fill
  // points at an unfilled entry, tail is free).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_filled <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        r_tag_rd[i]   <= '0;
        r_tag_data[i] <= '0;
      end
    end else begin
      if (w_mul_win) r_tag_filled[r_head] <= 1'b0;
      if (w_issue_ok) begin
        r_tag_rd[r_tail]     <= mul_rd_i;
        r_tag_filled[r_tail] <= 1'b0;
      end
      if (w_fill_ok) begin
        r_tag_data[r_fill]   <= mul_result_i;
        r_tag_filled[r_fill] <= 1'b1;
      end
    end
  end

  // Starvation counter: counts ALU wins over a waiting filled head, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_mul_win) begin
      r_starve <= '0;
    end else if (w_alu_win && w_head_rdy && (r_starve != L_SLIM)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Writeback register: winner loads rd/data; x0 targets consume without a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else if (w_mul_win) begin
      r_wb_en   <= (r_tag_rd[r_head] != '0);
      r_wb_rd   <= r_tag_rd[r_head];
      r_wb_data <= r_tag_data[r_head];
    end else if (w_alu_win) begin
      r_wb_en   <= (alu_rd_i != '0);
      r_wb_rd   <= alu_rd_i;
      r_wb_data <= alu_result_i;
    end else begin
      r_wb_en   <= 1'b0;
    end
  end

  // Sticky protocol error: issue into a full queue or a result with nothing pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((mul_issue_i && w_full) || (mul_valid_result_i && !w_fill_ok)) begin
      r_err <= 1'b1;
    end
  end

endmodule
